// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side and hazard-unit-side signal bundle
interface hazard_unit_if;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        mem_access;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_hold;
  logic        mem_error;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  state;

  // pipeline side: reports instruction/memory status, consumes enables
  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rt,
           ex_branch_taken, mem_access, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_error, stall_cnt, flush_cnt, state
  );

  // hazard unit side
  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_mem_read, ex_rt,
           ex_branch_taken, mem_access, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_error, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/freeze sequencing for the 5-stage MIPS pipeline
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  hazard_unit_if.slave hz
);

  localparam int unsigned      WCW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]   WAIT_LIMIT = WCW'(MEM_TIMEOUT);
  localparam logic [15:0]      CNT_MAX    = 16'hFFFF;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_error_q, mem_error_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;
  logic [15:0]    flush_cnt_q, flush_cnt_d;

  logic uses_rs, uses_rt, load_use, jump_id, mem_stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;

  // decode which source registers the IF/ID instruction reads, and detect load-use/jump
  always_comb begin
    uses_rs  = hz.id_valid & ((hz.id_opcode == OP_RTYPE) | (hz.id_opcode == OP_LW) |
                              (hz.id_opcode == OP_SW)    | (hz.id_opcode == OP_BEQ));
    uses_rt  = hz.id_valid & ((hz.id_opcode == OP_RTYPE) | (hz.id_opcode == OP_SW) |
                              (hz.id_opcode == OP_BEQ));
    load_use = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
               ((uses_rs & (hz.ex_rt == hz.id_rs)) | (uses_rt & (hz.ex_rt == hz.id_rt)));
    jump_id  = hz.id_valid & (hz.id_opcode == OP_J);
  end

  // memory-wait FSM: freeze while data memory is busy, give up after MEM_TIMEOUT held cycles
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    mem_stall   = 1'b0;
    case (state_q)
      RUN: begin
        mem_stall = hz.mem_access & ~hz.mem_ready;
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        mem_stall = ~hz.mem_ready & (wait_cnt_q != WAIT_LIMIT);
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d     = RUN;
          wait_cnt_d  = '0;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // prioritized pipeline enables; reset holds the pipe flushed and the PC still
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (hz.ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (jump_id) begin
      if_id_flush = 1'b1;
    end
  end

  // saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (if_id_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // state, wait counter, error flag and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.pipe_hold    = pipe_hold;
  assign hz.mem_error    = mem_error_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;
  assign hz.state        = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;
  localparam int T = 15;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  hazard_unit_if hz_if();
  hazard_unit #(.MEM_TIMEOUT(T)) dut (.clock(clock), .reset_n(reset_n), .hz(hz_if));

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_wait;
  int m_held;
  bit m_err;
  int m_stall;
  int m_flush;

  typedef struct {
    logic       vld;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] xrt;
    logic       br, acc, rdy;
    logic [4:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic vld, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                        input logic br, input logic acc, input logic rdy);
    hz_if.id_valid = vld; hz_if.id_opcode = op; hz_if.id_rs = rs; hz_if.id_rt = rt;
    hz_if.ex_mem_read = mr; hz_if.ex_rt = xrt; hz_if.ex_branch_taken = br;
    hz_if.mem_access = acc; hz_if.mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  function automatic vec_t mk(input logic vld, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                              input logic br, input logic acc, input logic rdy,
                              input logic [4:0] exp);
    vec_t v;
    v.vld = vld; v.op = op; v.rs = rs; v.rt = rt; v.mr = mr; v.xrt = xrt;
    v.br = br; v.acc = acc; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] dut_ctrl();
    return {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush, hz_if.id_ex_bubble, hz_if.pipe_hold};
  endfunction

  // spec rules evaluated directly on the current inputs and model wait bookkeeping
  function automatic logic [4:0] model_ctrl();
    bit reads_rs, reads_rt, lu, jmp, frozen;
    int op;
    op       = int'(hz_if.id_opcode);
    reads_rs = hz_if.id_valid && (op == 0 || op == 35 || op == 43 || op == 4);
    reads_rt = hz_if.id_valid && (op == 0 || op == 43 || op == 4);
    lu  = hz_if.ex_mem_read && hz_if.ex_rt != 0 &&
          ((reads_rs && hz_if.ex_rt == hz_if.id_rs) || (reads_rt && hz_if.ex_rt == hz_if.id_rt));
    jmp = hz_if.id_valid && op == 2;
    if (m_wait) frozen = !hz_if.mem_ready && m_held < T;
    else        frozen = hz_if.mem_access && !hz_if.mem_ready;
    if (frozen)                     return 5'b00001;
    if (hz_if.ex_branch_taken)      return 5'b11110;
    if (lu)                         return 5'b00010;
    if (jmp)                        return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_held = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // one clock: compare at negedge against model (and optional explicit values), then advance
  task automatic step(input bit hx, input string nm, input logic [4:0] ec, input logic [1:0] es);
    logic [4:0] mc;
    bit nw, ne;
    int nh;
    @(negedge clock);
    mc = model_ctrl();
    chk($sformatf("%s/model_ctrl", nm), 32'(dut_ctrl()), 32'(mc));
    chk($sformatf("%s/model_state", nm), 32'(hz_if.state), m_wait ? 32'd1 : 32'd0);
    chk($sformatf("%s/model_stall_cnt", nm), 32'(hz_if.stall_cnt), 32'(m_stall));
    chk($sformatf("%s/model_flush_cnt", nm), 32'(hz_if.flush_cnt), 32'(m_flush));
    chk($sformatf("%s/model_mem_error", nm), 32'(hz_if.mem_error), 32'(m_err));
    if (hx) begin
      chk($sformatf("%s/ctrl", nm), 32'(dut_ctrl()), 32'(ec));
      chk($sformatf("%s/state", nm), 32'(hz_if.state), 32'(es));
    end
    nw = m_wait; nh = m_held; ne = m_err;
    if (!m_wait) begin
      if (hz_if.mem_access && !hz_if.mem_ready) begin nw = 1; nh = 1; end
    end else if (hz_if.mem_ready) begin
      nw = 0; nh = 0;
    end else if (m_held >= T) begin
      nw = 0; nh = 0; ne = 1;
    end else begin
      nh = m_held + 1;
    end
    @(posedge clock);
    #1;
    m_wait = nw; m_held = nh; m_err = ne;
    if (!mc[4] && m_stall < 65535) m_stall++;
    if (mc[2] && m_flush < 65535) m_flush++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int e_st, e_fl;
    logic [5:0] ops[6];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

    tbl[0]  = mk(1, 6'b000000, 5'd2, 5'd4, 1, 5'd2, 0, 0, 0, 5'b00010); // add after lw
    tbl[1]  = mk(1, 6'b000000, 5'd0, 5'd4, 1, 5'd0, 0, 0, 0, 5'b11000); // ex_rt = $0
    tbl[2]  = mk(1, 6'b000000, 5'd2, 5'd4, 1, 5'd2, 1, 0, 0, 5'b11110); // branch beats load-use
    tbl[3]  = mk(1, 6'b000010, 5'd2, 5'd2, 1, 5'd2, 0, 0, 0, 5'b11100); // jump never stalls
    tbl[4]  = mk(1, 6'b100011, 5'd5, 5'd2, 1, 5'd2, 0, 0, 0, 5'b11000); // lw rt is a dest
    tbl[5]  = mk(1, 6'b100011, 5'd2, 5'd7, 1, 5'd2, 0, 0, 0, 5'b00010); // lw base match
    tbl[6]  = mk(1, 6'b101011, 5'd7, 5'd2, 1, 5'd2, 0, 0, 0, 5'b00010); // sw data match
    tbl[7]  = mk(1, 6'b000100, 5'd7, 5'd2, 1, 5'd2, 0, 0, 0, 5'b00010); // beq rt match
    tbl[8]  = mk(0, 6'b000000, 5'd2, 5'd2, 1, 5'd2, 0, 0, 0, 5'b11000); // bubble in IF/ID
    tbl[9]  = mk(1, 6'b000000, 5'd2, 5'd4, 1, 5'd2, 0, 1, 1, 5'b00010); // ready same cycle
    tbl[10] = mk(1, 6'b001000, 5'd2, 5'd2, 1, 5'd2, 0, 0, 0, 5'b11000); // opcode not decoded
    tbl[11] = mk(0, 6'b000000, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 5'b11110); // branch alone
    tbl[12] = mk(0, 6'b000010, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 5'b11000); // invalid jump
    tbl[13] = mk(1, 6'b000000, 5'd2, 5'd2, 0, 5'd2, 0, 0, 0, 5'b11000); // not a load

    // reset state
    reset_n = 1'b0;
    idle();
    model_reset();
    #2;
    chk("reset/ctrl", 32'(dut_ctrl()), 32'b00110);
    chk("reset/state", 32'(hz_if.state), 0);
    chk("reset/stall_cnt", 32'(hz_if.stall_cnt), 0);
    chk("reset/flush_cnt", 32'(hz_if.flush_cnt), 0);
    chk("reset/mem_error", 32'(hz_if.mem_error), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(1, "idle", 5'b11000, 2'b00);

    // table vectors
    e_st = 0; e_fl = 0;
    foreach (tbl[i]) begin
      set_in(tbl[i].vld, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].xrt,
             tbl[i].br, tbl[i].acc, tbl[i].rdy);
      step(1, $sformatf("vec%0d", i), tbl[i].exp, 2'b00);
      if (!tbl[i].exp[4]) e_st++;
      if (tbl[i].exp[2])  e_fl++;
    end
    chk("table/stall_cnt", 32'(hz_if.stall_cnt), 32'(e_st));
    chk("table/flush_cnt", 32'(hz_if.flush_cnt), 32'(e_fl));

    // load-use stalls one cycle, then the load is in MEM and the consumer proceeds
    do_reset();
    set_in(1, 6'b000000, 5'd2, 5'd4, 1, 5'd2, 0, 0, 0);
    step(1, "lu/stall", 5'b00010, 2'b00);
    set_in(1, 6'b000000, 5'd2, 5'd4, 0, 5'd0, 0, 1, 1);
    step(1, "lu/proceed", 5'b11000, 2'b00);
    chk("lu/stall_cnt", 32'(hz_if.stall_cnt), 1);

    // memory ready on the 4th cycle, with a branch arriving mid-hold
    do_reset();
    set_in(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    step(1, "mw/c1", 5'b00001, 2'b00);
    hz_if.ex_branch_taken = 1'b1;
    step(1, "mw/c2", 5'b00001, 2'b01);
    step(1, "mw/c3", 5'b00001, 2'b01);
    hz_if.mem_ready = 1'b1;
    step(1, "mw/c4", 5'b11110, 2'b01);
    idle();
    step(1, "mw/after", 5'b11000, 2'b00);
    chk("mw/stall_cnt", 32'(hz_if.stall_cnt), 3);
    chk("mw/flush_cnt", 32'(hz_if.flush_cnt), 1);

    // timeout: 15 held cycles, release on the 16th, sticky error
    do_reset();
    set_in(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 1; i <= T; i++)
      step(1, $sformatf("to/hold%0d", i), 5'b00001, (i == 1) ? 2'b00 : 2'b01);
    step(1, "to/release", 5'b11000, 2'b01);
    chk("to/mem_error", 32'(hz_if.mem_error), 1);
    chk("to/state", 32'(hz_if.state), 0);
    chk("to/stall_cnt", 32'(hz_if.stall_cnt), 32'(T));
    idle();
    for (int i = 0; i < 3; i++) step(1, "to/idle", 5'b11000, 2'b00);
    chk("to/mem_error_sticky", 32'(hz_if.mem_error), 1);

    // randomized stimulus against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      set_in(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 3) == 0));
      step(0, "rand", 5'b0, 2'b00);
    end

    // asynchronous reset in the middle of a memory wait
    do_reset();
    set_in(1, 6'b000010, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, "rst_mw", 5'b0, 2'b00);
    chk("rst_mw/pre_state", 32'(hz_if.state), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mw/state", 32'(hz_if.state), 0);
    chk("rst_mw/stall_cnt", 32'(hz_if.stall_cnt), 0);
    chk("rst_mw/flush_cnt", 32'(hz_if.flush_cnt), 0);
    chk("rst_mw/mem_error", 32'(hz_if.mem_error), 0);
    chk("rst_mw/ctrl", 32'(dut_ctrl()), 32'b00110);

    // stall counter saturation under a continuous load-use stall
    do_reset();
    set_in(1, 6'b000000, 5'd3, 5'd3, 1, 5'd3, 0, 0, 0);
    repeat (65535) @(posedge clock);
    #1;
    chk("sat/reach", 32'(hz_if.stall_cnt), 32'hFFFF);
    repeat (5) @(posedge clock);
    #1;
    chk("sat/hold", 32'(hz_if.stall_cnt), 32'hFFFF);
    chk("sat/pc_write", 32'(hz_if.pc_write), 0);
    chk("sat/flush_cnt", 32'(hz_if.flush_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the main control unit and drives the stall, flush and freeze enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch and jump flushes, and multi-cycle data-memory waits, and it bounds each wait with a timeout. It also keeps saturating stall and flush counters for performance visibility.

## Interface
- MEM_TIMEOUT, 15: maximum held cycles per data-memory access (legal range 2..255).
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction, i.e. the instruction word is not 32'b0.
- id_opcode  in  6  opcode of the instruction in IF/ID.
- id_rs, id_rt  in  5 each  source register fields in IF/ID.
- ex_mem_read  in  1  instruction in ID/EX is a load (lw).
- ex_rt  in  5  destination register of the load in ID/EX.
- ex_branch_taken  in  1  beq in EX with equal operands.
- mem_access  in  1  instruction in EX/MEM is lw or sw.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  load 32'b0 into IF/ID.
- id_ex_bubble  out  1  zero all ID/EX control bits.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- mem_error  out  1  sticky flag: a memory wait timed out.
- stall_cnt  out  16  saturating count of cycles with pc_write=0, reset excluded.
- flush_cnt  out  16  saturating count of branch and jump flush events.
- state  out  2  FSM state: RUN=2'b00, MEM_WAIT=2'b01.

## Operation
- Register-use decode:
  - uses_rs = id_valid and opcode in {000000, 100011, 101011, 000100}.
  - uses_rt = id_valid and opcode in {000000, 101011, 000100}.
- load_use = ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- jump_id = id_valid & id_opcode == 6'b000010.
- mem_stall:
  - In RUN: mem_access & !mem_ready.
  - In MEM_WAIT: !mem_ready & wait_cnt != MEM_TIMEOUT.
- Output priority, highest first. Default is pc_write=1, if_id_write=1, all other control outputs 0.
  1. mem_stall: pc_write=0, if_id_write=0, pipe_hold=1. Flush and bubble stay 0; branch, jump and load-use are deferred while frozen.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1.
  3. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1.
  4. jump_id: pc_write=1, if_id_flush=1.
- FSM:
  - RUN -> MEM_WAIT when mem_access & !mem_ready. wait_cnt is loaded with 1.
  - MEM_WAIT with mem_ready: release this cycle, return to RUN.
  - MEM_WAIT with !mem_ready and wait_cnt == MEM_TIMEOUT: release this cycle, set mem_error, return to RUN.
  - MEM_WAIT otherwise: hold, wait_cnt += 1.
- wait_cnt width is clog2(MEM_TIMEOUT+1). Total held cycles per access never exceed MEM_TIMEOUT.
- Counters:
  - stall_cnt += 1 on each cycle with pc_write=0; holds at 16'hFFFF.
  - flush_cnt += 1 on each cycle with if_id_flush=1; holds at 16'hFFFF.
- mem_error is cleared only by reset.

## Timing
- Control outputs are combinational from the registered state, wait_cnt and current inputs, with zero latency. The state, wait_cnt, counters and mem_error update on the rising clock edge.
- Reset while reset_n=0, asynchronous and valid mid-wait:
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_error=0.
  - Outputs forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
- Load-use stalls exactly 1 cycle. Next cycle the load has moved to MEM and the stalled instruction proceeds.
- A taken branch costs 2 flushed slots in a single cycle. A jump costs 1 flushed slot.
- Simultaneous taken branch and load-use: the branch wins, and no stall is counted.
- A branch that arrives during a memory hold stays in EX and takes effect in the release cycle, unless the release cycle is itself a stall.
- mem_ready in the same cycle mem_access rises: no hold, and the FSM stays in RUN.

## Test plan
- Load-use: lw $2 in ID/EX, add $3,$2,$4 in IF/ID -> exactly 1 cycle with pc_write=0 and id_ex_bubble=1; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- Taken branch plus load-use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Jump in IF/ID -> if_id_flush=1 for 1 cycle; a jump whose rs bits match ex_rt of a load does not stall.
- mem_access with mem_ready arriving on the 4th cycle -> pipe_hold=1 for 3 cycles, state=01 for 2 of them, release in cycle 4; stall_cnt=3.
- mem_ready held 0 with MEM_TIMEOUT=15 -> 15 held cycles, release on the 16th, mem_error=1 and stays 1; state returns to 00.
- Assert reset_n mid MEM_WAIT -> state=00, counters 0, mem_error 0 immediately; stall_cnt forced to 16'hFFFF saturates and does not wrap.
